// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames the UART receiver's byte stream into command packets.
// Frame: SYNC, CMD, LEN_H, LEN_L, N payload bytes, CHK (8-bit sum of CMD..payload).
// Payload bytes are streamed to a buffer write port; a good packet is held
// on pkt_valid until pkt_ack, bad/oversized/stalled packets pulse pkt_err.
module uart_rx_pkt_ctrl #(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              pkt_valid,
    output logic [7:0]        pkt_cmd,
    output logic [15:0]       pkt_len,
    input  logic              pkt_ack,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned TMO_W   = 20;
    localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK, S_HOLD
    } state_e;

    state_e             state_q;
    logic [7:0]         sum_q;
    logic [15:0]        len_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [TMO_W-1:0]   tmo_q;

    logic [15:0] len_n_c;
    logic [7:0]  sum_n_c;
    logic        active_c;
    logic        tmo_hit_c;

    // Combinational helpers: full length once LEN_L arrives, next sum, timeout window
    always_comb begin
        len_n_c   = {len_q[15:8], rx_data};
        sum_n_c   = sum_q + rx_data;
        active_c  = (state_q == S_CMD) || (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
        tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Packet FSM with all outputs registered; rx_done always wins over timeout
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sum_q     <= 8'd0;
            len_q     <= 16'd0;
            idx_q     <= '0;
            tmo_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
            pkt_valid <= 1'b0;
            pkt_cmd   <= 8'd0;
            pkt_len   <= 16'd0;
            pkt_err   <= 1'b0;
            err_code  <= 2'b00;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            pkt_err <= 1'b0;

            // Inter-byte idle counter, only meaningful inside a packet
            if (rx_done || !active_c) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (active_c && !rx_done && tmo_hit_c) begin
                pkt_err  <= 1'b1;
                err_code <= ERR_TMO;
                state_q  <= S_IDLE;
                busy     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_done && (rx_data == SYNC_BYTE)) begin
                            state_q <= S_CMD;
                            busy    <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (rx_done) begin
                            pkt_cmd <= rx_data;
                            sum_q   <= rx_data;
                            state_q <= S_LEN_H;
                        end
                    end
                    S_LEN_H: begin
                        if (rx_done) begin
                            len_q[15:8] <= rx_data;
                            sum_q       <= sum_n_c;
                            state_q     <= S_LEN_L;
                        end
                    end
                    S_LEN_L: begin
                        if (rx_done) begin
                            len_q[7:0] <= rx_data;
                            sum_q      <= sum_n_c;
                            if (32'(len_n_c) > MAX_LEN) begin
                                pkt_err  <= 1'b1;
                                err_code <= ERR_LEN;
                                state_q  <= S_IDLE;
                                busy     <= 1'b0;
                            end else if (len_n_c == 16'd0) begin
                                state_q <= S_CHK;
                            end else begin
                                idx_q   <= '0;
                                state_q <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_done) begin
                            wr_en   <= 1'b1;
                            wr_addr <= idx_q;
                            wr_data <= rx_data;
                            sum_q   <= sum_n_c;
                            idx_q   <= idx_q + ADDR_W'(1);
                            if ((32'(idx_q) + 32'd1) == 32'(len_q)) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (rx_done) begin
                            if (rx_data == sum_q) begin
                                pkt_valid <= 1'b1;
                                pkt_len   <= len_q;
                                state_q   <= S_HOLD;
                            end else begin
                                pkt_err  <= 1'b1;
                                err_code <= ERR_CHK;
                                state_q  <= S_IDLE;
                                busy     <= 1'b0;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (pkt_ack) begin
                            pkt_valid <= 1'b0;
                            overrun   <= 1'b0;
                            state_q   <= S_IDLE;
                            busy      <= 1'b0;
                        end else if (rx_done) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
